// File: rtl/dpb_rr_arbiter.sv
// dpb_rr_arbiter: two-requester round-robin arbiter in front of one port of a
// 128x16 dual-port block RAM (bypass read mode, synchronous output reset).
//
// Ports:
//   clk, reset               clock; asynchronous active-high reset
//   reqN_valid/ready         request handshake; ready is the same-cycle grant
//   reqN_we/addr/wdata       request payload (1 = write)
//   rspN_valid/rdata         read response, one-cycle pulse, rdata 0 when idle
//   mem_ce/oce/wre/reset     RAM port controls (oce tied 1, reset = reset)
//   mem_ad/din               RAM address and write data, 0 when no grant
//   mem_dout                 RAM read data, valid one cycle after the grant
module dpb_rr_arbiter #(
    parameter int unsigned ADDR_W = 7,
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic              req0_we,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic              req1_we,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_rdata,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_rdata,
    output logic              mem_ce,
    output logic              mem_oce,
    output logic              mem_wre,
    output logic              mem_reset,
    output logic [ADDR_W-1:0] mem_ad,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout
);

    // prio_q: requester that wins a tie (0 or 1)
    logic prio_q, prio_d;
    // rd_pend_q/rd_id_q: a read was granted last cycle, and to whom
    logic rd_pend_q, rd_pend_d;
    logic rd_id_q, rd_id_d;

    logic              gnt0_c, gnt1_c, any_gnt_c;
    logic              win_we_c;
    logic [ADDR_W-1:0] win_addr_c;
    logic [DATA_W-1:0] win_wdata_c;

    // Grant selection; no grant is issued while reset is held
    always_comb begin
        gnt0_c = 1'b0;
        gnt1_c = 1'b0;
        if (!reset) begin
            if (req0_valid && (!req1_valid || !prio_q)) begin
                gnt0_c = 1'b1;
            end else if (req1_valid) begin
                gnt1_c = 1'b1;
            end
        end
    end

    assign any_gnt_c = gnt0_c | gnt1_c;

    // Winner payload mux
    always_comb begin
        win_we_c    = req0_we;
        win_addr_c  = req0_addr;
        win_wdata_c = req0_wdata;
        if (gnt1_c) begin
            win_we_c    = req1_we;
            win_addr_c  = req1_addr;
            win_wdata_c = req1_wdata;
        end
    end

    assign req0_ready = gnt0_c;
    assign req1_ready = gnt1_c;

    // RAM port drive; all lines are zeroed when nothing is granted
    always_comb begin
        mem_ce  = 1'b0;
        mem_wre = 1'b0;
        mem_ad  = '0;
        mem_din = '0;
        if (any_gnt_c) begin
            mem_ce  = 1'b1;
            mem_wre = win_we_c;
            mem_ad  = win_addr_c;
            mem_din = win_wdata_c;
        end
    end

    assign mem_oce   = 1'b1;
    assign mem_reset = reset;

    // Next-state: priority passes to the loser on every grant
    always_comb begin
        prio_d    = prio_q;
        rd_pend_d = 1'b0;
        rd_id_d   = rd_id_q;
        if (any_gnt_c) begin
            prio_d = ~gnt1_c;
            if (!win_we_c) begin
                rd_pend_d = 1'b1;
                rd_id_d   = gnt1_c;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prio_q    <= 1'b0;
            rd_pend_q <= 1'b0;
            rd_id_q   <= 1'b0;
        end else begin
            prio_q    <= prio_d;
            rd_pend_q <= rd_pend_d;
            rd_id_q   <= rd_id_d;
        end
    end

    // Response steering: RAM data goes only to the requester that issued the read
    assign rsp0_valid = rd_pend_q & ~rd_id_q;
    assign rsp1_valid = rd_pend_q & rd_id_q;
    assign rsp0_rdata = rsp0_valid ? mem_dout : '0;
    assign rsp1_rdata = rsp1_valid ? mem_dout : '0;

endmodule

// File: tb/tb_dpb_rr_arbiter.sv
// Bench for dpb_rr_arbiter: behavioural RAM on the arbiter port, reference
// arbiter/memory model, and a queue of expected read responses.
module tb_dpb_rr_arbiter;

    localparam int unsigned AW = 7;
    localparam int unsigned DW = 16;

    typedef struct packed {
        logic          v;
        logic          we;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } req_t;

    typedef struct packed {
        logic          v0;
        logic [DW-1:0] d0;
        logic          v1;
        logic [DW-1:0] d1;
    } rsp_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          req0_valid = 1'b0, req0_we = 1'b0;
    logic [AW-1:0] req0_addr = '0;
    logic [DW-1:0] req0_wdata = '0;
    logic          req1_valid = 1'b0, req1_we = 1'b0;
    logic [AW-1:0] req1_addr = '0;
    logic [DW-1:0] req1_wdata = '0;
    logic          req0_ready, req1_ready;
    logic          rsp0_valid, rsp1_valid;
    logic [DW-1:0] rsp0_rdata, rsp1_rdata;
    logic          mem_ce, mem_oce, mem_wre, mem_reset;
    logic [AW-1:0] mem_ad;
    logic [DW-1:0] mem_din;
    logic [DW-1:0] mem_dout = '0;

    dpb_rr_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_we    (req0_we),
        .req0_addr  (req0_addr),
        .req0_wdata (req0_wdata),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_we    (req1_we),
        .req1_addr  (req1_addr),
        .req1_wdata (req1_wdata),
        .rsp0_valid (rsp0_valid),
        .rsp0_rdata (rsp0_rdata),
        .rsp1_valid (rsp1_valid),
        .rsp1_rdata (rsp1_rdata),
        .mem_ce     (mem_ce),
        .mem_oce    (mem_oce),
        .mem_wre    (mem_wre),
        .mem_reset  (mem_reset),
        .mem_ad     (mem_ad),
        .mem_din    (mem_din),
        .mem_dout   (mem_dout)
    );

    always #5 clk = ~clk;

    // Behavioural RAM port: bypass (write-through) read, synchronous output reset
    logic [DW-1:0] ram [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (mem_reset) begin
            mem_dout <= '0;
        end else if (mem_ce) begin
            if (mem_wre) begin
                ram[mem_ad] <= mem_din;
                mem_dout    <= mem_din;
            end else begin
                mem_dout <= ram[mem_ad];
            end
        end
    end

    // Reference model state
    logic [DW-1:0] ref_mem [0:(1<<AW)-1];
    logic          m_prio = 1'b0;
    rsp_t          exp_q[$];
    logic          rst_drv = 1'b1;
    int            wait0 = 0, wait1 = 0;
    int            n_vec = 0, n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic req_t mk(input logic v, input logic we, input logic [AW-1:0] a,
                                input logic [DW-1:0] d);
        req_t r;
        r.v = v; r.we = we; r.a = a; r.d = d;
        return r;
    endfunction

    // One clock: drive at the falling edge, check 1 time unit later, update model
    task automatic tick(input req_t r0, input req_t r1);
        rsp_t e;
        logic g0, g1, wwe;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        @(negedge clk);
        reset      = rst_drv;
        req0_valid = r0.v; req0_we = r0.we; req0_addr = r0.a; req0_wdata = r0.d;
        req1_valid = r1.v; req1_we = r1.we; req1_addr = r1.a; req1_wdata = r1.d;
        #1;
        e = '0;
        if (exp_q.size() > 0) e = exp_q.pop_front();
        if (reset) begin
            e = '0;
            exp_q.delete();
            m_prio = 1'b0;
        end
        chk("rsp0_valid", 32'(rsp0_valid), 32'(e.v0));
        chk("rsp0_rdata", 32'(rsp0_rdata), 32'(e.d0));
        chk("rsp1_valid", 32'(rsp1_valid), 32'(e.v1));
        chk("rsp1_rdata", 32'(rsp1_rdata), 32'(e.d1));

        g0 = 1'b0; g1 = 1'b0;
        if (!reset) begin
            if (r0.v && r1.v) begin
                g0 = ~m_prio; g1 = m_prio;
            end else begin
                g0 = r0.v; g1 = r1.v;
            end
        end
        wwe = g1 ? r1.we : r0.we;
        wa  = g1 ? r1.a  : r0.a;
        wd  = g1 ? r1.d  : r0.d;
        chk("req0_ready", 32'(req0_ready), 32'(g0));
        chk("req1_ready", 32'(req1_ready), 32'(g1));
        chk("mem_ce",  32'(mem_ce),  32'(g0 | g1));
        chk("mem_wre", 32'(mem_wre), 32'((g0 | g1) & wwe));
        chk("mem_ad",  32'(mem_ad),  (g0 | g1) ? 32'(wa) : 32'd0);
        chk("mem_din", 32'(mem_din), (g0 | g1) ? 32'(wd) : 32'd0);
        chk("mem_oce", 32'(mem_oce), 32'd1);
        chk("mem_reset", 32'(mem_reset), 32'(reset));
        chk("rdy_excl", 32'(req0_ready & req1_ready), 32'd0);
        chk("rdy_no_valid", 32'((req0_ready & ~r0.v) | (req1_ready & ~r1.v)), 32'd0);

        // Starvation watch: no requester refused twice in a row while the other holds valid
        if (reset) begin
            wait0 = 0; wait1 = 0;
        end else begin
            wait0 = (r0.v && !req0_ready) ? wait0 + 1 : 0;
            wait1 = (r1.v && !req1_ready) ? wait1 + 1 : 0;
            chk("starve", 32'(wait0 > 1 || wait1 > 1), 32'd0);
        end

        e = '0;
        if (g0 | g1) begin
            m_prio = g0;
            if (wwe) begin
                ref_mem[wa] = wd;
            end else if (g0) begin
                e.v0 = 1'b1; e.d0 = ref_mem[wa];
            end else begin
                e.v1 = 1'b1; e.d1 = ref_mem[wa];
            end
        end
        exp_q.push_back(e);
    endtask

    req_t idle, rd0_05, rd1_7f;

    initial begin
        for (int i = 0; i < (1 << AW); i++) begin
            ram[i]     = DW'(i * 16'h0135 + 16'h0F00);
            ref_mem[i] = DW'(i * 16'h0135 + 16'h0F00);
        end
        ram[7'h05] = 16'hA5A5; ref_mem[7'h05] = 16'hA5A5;
        ram[7'h7F] = 16'h1234; ref_mem[7'h7F] = 16'h1234;
        idle   = mk(1'b0, 1'b0, 7'h00, 16'h0000);
        rd0_05 = mk(1'b1, 1'b0, 7'h05, 16'h0000);
        rd1_7f = mk(1'b1, 1'b0, 7'h7F, 16'h0000);

        // Reset held with both requesters valid
        rst_drv = 1'b1;
        for (int i = 0; i < 3; i++) tick(rd0_05, rd1_7f);
        rst_drv = 1'b0;

        // Contention: grants alternate starting with requester 0
        for (int i = 0; i < 6; i++) begin
            tick(rd0_05, rd1_7f);
            chk("contend_gnt", 32'(req1_ready), 32'(i % 2));
        end
        tick(idle, idle);

        // Lone requester 1: write then read-back of the same address
        tick(idle, mk(1'b1, 1'b1, 7'h10, 16'hBEEF));
        tick(idle, mk(1'b1, 1'b0, 7'h10, 16'h0000));
        tick(idle, idle);
        chk("raw_prev_rsp", 32'(ref_mem[7'h10]), 32'hBEEF);

        // Priority hold across idle cycles
        tick(rd0_05, idle);
        for (int i = 0; i < 3; i++) tick(idle, idle);
        tick(rd0_05, rd1_7f);
        chk("prio_hold", 32'(req1_ready), 32'd1);
        tick(idle, idle);

        // Reset mid-read: the pending read must not respond
        tick(mk(1'b1, 1'b0, 7'h20, 16'h0000), idle);
        reset   = 1'b1;
        rst_drv = 1'b1;
        exp_q.delete();
        m_prio  = 1'b0;
        #1;
        chk("rd_pend_async", 32'(dut.rd_pend_q), 32'd0);
        tick(idle, idle);
        chk("rd_pend_rst", 32'(dut.rd_pend_q), 32'd0);
        rst_drv = 1'b0;
        tick(mk(1'b1, 1'b0, 7'h20, 16'h0000), idle);
        tick(idle, idle);

        // Random soak against the reference model
        for (int i = 0; i < 10000; i++) begin
            tick(mk(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    AW'($urandom), DW'($urandom)),
                 mk(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    AW'($urandom), DW'($urandom)));
        end
        tick(idle, idle);
        tick(idle, idle);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dpb_rr_arbiter.md
# dpb_rr_arbiter

Two-requester round-robin arbiter that shares one port of the 128×16 dual-port block RAM (Gowin_DPB, bypass read mode, synchronous reset) between two independent masters. Each master sees a valid/ready request channel and a read-response channel. The arbiter drives the RAM port's clock-enable, write-enable and address/data lines, and routes the read data back to the master that issued the read. The arbiter sits directly in front of port A or port B of the RAM; the other RAM port remains free.

## Interface
- ADDR_W, 7, word address width (128 words)
- DATA_W, 16, data width
- clk  in  1  single clock; the RAM port clock is driven from the same net
- reset  in  1  asynchronous, active-high
- req0_valid, req1_valid  in  1  request present
- req0_ready, req1_ready  out  1  request accepted this cycle (grant)
- req0_we, req1_we  in  1  1 = write, 0 = read
- req0_addr, req1_addr  in  ADDR_W  word address
- req0_wdata, req1_wdata  in  DATA_W  write data
- rsp0_valid, rsp1_valid  out  1  read data valid (one-cycle pulse)
- rsp0_rdata, rsp1_rdata  out  DATA_W  read data
- mem_ce  out  1  RAM clock enable
- mem_oce  out  1  RAM output clock enable, tied 1
- mem_wre  out  1  RAM write enable
- mem_reset  out  1  RAM output-register reset, equals reset
- mem_ad  out  ADDR_W  RAM address
- mem_din  out  DATA_W  RAM write data
- mem_dout  in  DATA_W  RAM read data, valid one cycle after the address is sampled

## Operation
- **Priority state:** `prio` is 1 bit. 0 means requester 0 wins a tie; 1 means requester 1 wins a tie. Reset value is 0.
- **Grant (combinational, same cycle):**
  - Only one requester valid: that requester is granted.
  - Both valid: the requester indicated by `prio` is granted.
  - Neither valid: no grant.
  - At most one `reqN_ready` is high per cycle.
  - `reqN_ready` is never high while `reqN_valid` is low.
- **Priority update:** on every grant, `prio` is set to the other requester. With no grant, `prio` holds.
  - Continuous contention therefore alternates grants 0, 1, 0, 1, …
  - A lone requester is granted every cycle (full throughput).
- **Memory drive in a granted cycle:**
  - `mem_ce=1`, `mem_wre=winner_we`, `mem_ad=winner_addr`, `mem_din=winner_wdata`.
  - With no grant: `mem_ce=0`, `mem_wre=0`, `mem_ad=0`, `mem_din=0`.
- **Read tracking:** a granted read registers `rd_pend=1` and `rd_id=winner`. A write or an idle cycle clears `rd_pend`.
- **Read response:** in the following cycle, `rsp<rd_id>_valid=1` and `rsp<rd_id>_rdata=mem_dout`.
  - The other response channel stays 0.
  - `rspN_rdata` is 0 whenever `rspN_valid=0`.
- **Writes produce no response.** Write completion is implied by the grant.
- **Request stability:** a requester holding valid with ready low keeps `we`/`addr`/`wdata` stable. The arbiter does not check this.
- **No backpressure on responses:** masters accept `rspN_valid` unconditionally.

## Timing
- **Reset values:**
  - `req*_ready=0`, `rsp*_valid=0`, `rsp*_rdata=0`
  - `mem_ce=0`, `mem_wre=0`, `mem_ad=0`, `mem_din=0`, `mem_oce=1`
  - `prio=0`, `rd_pend=0`
- **Reset mid-operation:**
  - Asserting reset clears `rd_pend` asynchronously, so a read granted in the cycle before reset produces no response.
  - `mem_reset` follows reset, so `mem_dout` is forced to 0 by the RAM on the next clock.
- **Latencies:**
  - Grant latency: 0 cycles from `reqN_valid` high to `reqN_ready` when uncontended.
  - Read latency: exactly 1 cycle from grant edge to `rspN_valid`.
- **Throughput:** one access per cycle total. Back-to-back reads from alternating requesters produce responses in the same alternating order, one per cycle.
- **Read-after-write, same address, consecutive cycles:** the read returns the new data (the write completes at the grant edge). Same-cycle conflicts cannot occur because only one request is granted.
- **Hazard not handled here:** an access on the opposite RAM port to the same address in the same cycle is outside this block's control. Its result is the RAM's undefined collision behaviour.
- **Sequential elements:** exactly `prio`, `rd_pend`, `rd_id`. All are async-reset, and there is no other state.

## Test plan
- **Reset:** assert reset for 3 cycles with both requesters valid. Expect all ready/rsp/mem outputs 0 and `mem_oce=1`. After release, the first contended grant goes to requester 0.
- **Contention:** both requesters hold valid reads for 6 cycles (req0 addr 0x05, req1 addr 0x7F, RAM preloaded 0x05→0xA5A5, 0x7F→0x1234).
  - Grants: 0, 1, 0, 1, 0, 1.
  - Responses one cycle later: `rsp0_rdata=0xA5A5` and `rsp1_rdata=0x1234`, alternating.
- **Lone requester:** req1 alone writes 0xBEEF to 0x10, then reads 0x10 in the next cycle.
  - Expect `req1_ready` on both cycles and `mem_wre` pattern 1, 0.
  - `rsp1_valid` one cycle after the read, with `rdata=0xBEEF`; `rsp0_valid` stays 0.
- **Priority hold across idle:** req0 is granted, then 3 idle cycles, then both valid.
  - Expect the grant to go to requester 1 (`prio` held at 1 across idle).
  - No `mem_ce` during the idle cycles.
- **Reset mid-read:** grant a req0 read at 0x20, then assert reset before the next edge.
  - Expect `rsp0_valid` to never pulse and `rd_pend=0`.
  - After release, a fresh read returns the correct data with 1-cycle latency.
- **Random soak:** 10k cycles of random valid/we/addr/wdata on both requesters against a reference memory model.
  - Check: never both ready, `ready` implies `valid`, every read response matches the model, and no requester waits more than 1 cycle while the other is valid.
